// File: rtl/adc_capture_ctrl_pkg.sv
// adc_capture_ctrl_pkg
// Shared definitions for the ADC capture sequencer: FSM state encoding,
// trigger mode codes and a helper that folds the reserved mode onto
// immediate triggering.
package adc_capture_ctrl_pkg;

  // Encoded FSM states; the numeric values are visible on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;

  // Mode 3 is reserved and behaves like an immediate trigger.
  function automatic logic [1:0] norm_trig_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? TRIG_IMM : mode;
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// adc_capture_ctrl_if
// Bundles the SPI-side read port (rd_req / rd_data / rd_valid) and the
// single-port sample RAM port owned by the capture controller.
//   master : the capture controller (drives RAM controls and read results)
//   slave  : the environment (RAM + readout requester)
interface adc_capture_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
);
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wren;
  logic              ram_rden;
  logic [DATA_W-1:0] ram_q;

  modport master (
    input  rd_req, ram_q,
    output rd_data, rd_valid, ram_addr, ram_wdata, ram_wren, ram_rden
  );

  modport slave (
    output rd_req, ram_q,
    input  rd_data, rd_valid, ram_addr, ram_wdata, ram_wren, ram_rden
  );
endinterface

// File: rtl/adc_capture_ctrl_trig_detect.sv
// adc_trig_detect
// Registers the live ADC stream (adc_q, plus the sample before it) and
// evaluates the trigger condition on the registered sample.
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   adc_data       : raw ADC sample, one per cycle
//   mode, level    : latched trigger mode and unsigned threshold
//   first          : high on the first cycle of trigger search
//   adc_q          : registered sample (the one being written this cycle)
//   trig           : combinational trigger condition for adc_q
module adc_trig_detect
  import adc_capture_ctrl_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] level,
  input  logic              first,
  output logic [DATA_W-1:0] adc_q,
  output logic              trig
);

  logic [DATA_W-1:0] adc_prev;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_q    <= '0;
      adc_prev <= '0;
    end else begin
      adc_q    <= adc_data;
      adc_prev <= adc_q;
    end
  end

  // Level modes look for a threshold crossing between consecutive samples;
  // anything else fires on the first search cycle.
  always_comb begin
    trig = first;
    case (mode)
      TRIG_RISE: trig = (adc_prev < level) && (adc_q >= level);
      TRIG_FALL: trig = (adc_prev >= level) && (adc_q < level);
      default:   trig = first;
    endcase
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
// Triggered capture sequencer for the single-port ADC sample RAM. Fills a
// pre-trigger window, searches for the trigger, completes the post-trigger
// window and then serves the buffer in trigger-aligned order.
//   sys_clk, rst_n      : clock, asynchronous active-low reset
//   arm                 : pulse, (re)starts a capture
//   trig_mode/level     : trigger setup, latched on arm
//   pretrig             : samples kept before the trigger, latched on arm
//   adc_data            : live ADC sample
//   bus (master)        : read port and RAM port
//   busy / done / state : status and debug state
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic [1:0]           trig_mode,
  input  logic [DATA_W-1:0]    trig_level,
  input  logic [ADDR_W-1:0]    pretrig,
  input  logic [DATA_W-1:0]    adc_data,
  adc_capture_ctrl_if.master   bus,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state
);

  state_t            state_q;
  logic [1:0]        mode_l;
  logic [DATA_W-1:0] level_l;
  logic [ADDR_W-1:0] pretrig_l;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] start_ptr;
  logic [ADDR_W-1:0] rd_idx;
  logic              wait_first;
  logic              rd_all;
  logic              rd_pend;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] adc_q;
  logic              trig;
  logic              wr_en;
  logic              rd_accept;

  adc_trig_detect #(.DATA_W(DATA_W)) u_trig (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .adc_data (adc_data),
    .mode     (mode_l),
    .level    (level_l),
    .first    (wait_first),
    .adc_q    (adc_q),
    .trig     (trig)
  );

  assign wr_en = (state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) ||
                 (state_q == ST_POST);

  // arm takes priority over a read; once all words are requested further
  // requests are dropped while the last word drains.
  assign rd_accept = (state_q == ST_DONE) && bus.rd_req && !arm && !rd_all;

  // The RAM is addressed combinationally so a read request reaches the RAM
  // in its own cycle, giving the two-cycle request-to-valid latency.
  assign bus.ram_wren  = wr_en;
  assign bus.ram_rden  = rd_accept;
  assign bus.ram_wdata = adc_q;
  assign bus.ram_addr  = (state_q == ST_DONE) ? (start_ptr + rd_idx) : wr_ptr;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;

  assign busy  = wr_en;
  assign done  = (state_q == ST_DONE);
  assign state = state_q;

  // cnt counts remaining PRE samples, then remaining POST samples.
  // The post-trigger length DEPTH-1-pretrig is simply ~pretrig in ADDR_W bits.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_l     <= TRIG_IMM;
      level_l    <= '0;
      pretrig_l  <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      start_ptr  <= '0;
      rd_idx     <= '0;
      wait_first <= 1'b0;
      rd_all     <= 1'b0;
      rd_pend    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (arm) begin
      mode_l     <= norm_trig_mode(trig_mode);
      level_l    <= trig_level;
      pretrig_l  <= pretrig;
      wr_ptr     <= '0;
      cnt        <= pretrig;
      start_ptr  <= '0;
      rd_idx     <= '0;
      wait_first <= 1'b1;
      rd_all     <= 1'b0;
      rd_pend    <= 1'b0;
      rd_valid_q <= 1'b0;
      state_q    <= (pretrig == '0) ? ST_WAIT_TRIG : ST_PRE;
    end else begin
      rd_pend    <= rd_accept;
      rd_valid_q <= rd_pend;
      if (rd_pend) begin
        rd_data_q <= bus.ram_q;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case (state_q)
        ST_PRE: begin
          if (cnt == ADDR_W'(1)) begin
            state_q <= ST_WAIT_TRIG;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT_TRIG: begin
          wait_first <= 1'b0;
          if (trig) begin
            start_ptr <= wr_ptr - pretrig_l;
            cnt       <= ~pretrig_l;
            rd_idx    <= '0;
            state_q   <= (pretrig_l == '1) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (cnt == ADDR_W'(1)) begin
            state_q <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (rd_accept) begin
            rd_idx <= rd_idx + 1'b1;
            if (rd_idx == '1) begin
              rd_all <= 1'b1;
            end
          end
          // The final word's rd_valid is the one with nothing behind it.
          if (rd_all && rd_valid_q && !rd_pend) begin
            rd_all  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl
// Self-checking bench for adc_capture_ctrl. A behavioural single-port RAM
// sits on the RAM side; ADC data is a programmable ramp restarted on arm.
// Capture scenarios come from a vector table; readout words are predicted
// from the ramp and checked through a scoreboard keyed on the cycle in which
// rd_valid must appear.
module tb_adc_capture_ctrl;
  import adc_capture_ctrl_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              sys_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic [1:0]        trig_mode = 2'd0;
  logic [DATA_W-1:0] trig_level = '0;
  logic [ADDR_W-1:0] pretrig = '0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              busy;
  logic              done;
  logic [2:0]        state;

  adc_capture_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  adc_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .pretrig    (pretrig),
    .adc_data   (adc_data),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  initial forever #5 sys_clk = ~sys_clk;

  // Sample RAM: synchronous write, registered read one cycle after rden.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge sys_clk) begin
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_rden) bus.ram_q <= mem[bus.ram_addr];
  end

  int cycle_cnt = 0;
  always @(posedge sys_clk) cycle_cnt <= cycle_cnt + 1;

  // Ramp source: sample k (k=0 in the arm cycle) = start + step*k mod 4096.
  int ramp_k = 0;
  int ramp_start = 0;
  int ramp_step = 1;
  initial forever begin
    @(posedge sys_clk);
    #2;
    if (arm) ramp_k = 0;
    else ramp_k++;
    adc_data = DATA_W'(ramp_start + ramp_step * ramp_k);
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;
  exp_t sb_q[$];

  // Every cycle: rd_valid must match the scoreboard head exactly, and the
  // RAM port must never read and write together or read outside DONE.
  initial forever begin
    logic exp_valid;
    exp_t e;
    @(negedge sys_clk);
    exp_valid = 1'b0;
    e = '{data: '0, cyc: 0};
    if (sb_q.size() > 0 && sb_q[0].cyc <= cycle_cnt) begin
      e = sb_q.pop_front();
      exp_valid = (e.cyc == cycle_cnt);
    end
    check_output("rd_valid", bus.rd_valid, exp_valid);
    if (exp_valid && bus.rd_valid) check_output("rd_data", bus.rd_data, e.data);
    check_output("wren_rden_excl", bus.ram_wren & bus.ram_rden, 0);
    check_output("rden_only_done", bus.ram_rden && (state != ST_DONE), 0);
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [1:0] mode;
    int         level;
    int         pre;
    int         start;
    int         step;
    int         exp0;
    int         exp_step;
    int         exp_done;
  } vec_t;
  vec_t vecs[5];

  task automatic apply_stimulus(input logic [1:0] m, input int lvl, input int pre,
                                input int start, input int step, output int arm_cyc);
    @(posedge sys_clk);
    #1;
    trig_mode  = m;
    trig_level = DATA_W'(lvl);
    pretrig    = ADDR_W'(pre);
    ramp_start = start;
    ramp_step  = step;
    arm        = 1'b1;
    arm_cyc    = cycle_cnt;
    @(posedge sys_clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (state == target) begin
        seen = cycle_cnt;
        break;
      end
    end
  endtask

  task automatic read_words(input int n, input int exp0, input int step);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
      bus.rd_req = 1'b1;
      sb_q.push_back('{data: DATA_W'(exp0 + step * i), cyc: cycle_cnt + 2});
    end
    @(posedge sys_clk);
    #1;
    bus.rd_req = 1'b0;
  endtask

  task automatic finish_capture(input vec_t v, input int arm_cyc);
    int seen;
    wait_state(ST_DONE, 4000, seen);
    check_output("done_latency", seen - arm_cyc, v.exp_done);
    if (seen < 0) return;
    check_output("done_flag", done, 1);
    check_output("busy_in_done", busy, 0);
    read_words(DEPTH, v.exp0, v.exp_step);
    repeat (4) @(negedge sys_clk);
    check_output("idle_after_read", state, ST_IDLE);
    check_output("done_after_read", done, 0);
  endtask

  initial begin
    int arm_cyc;
    int seen;
    logic rden_seen;
    bus.rd_req = 1'b0;

    vecs[0] = '{mode: 2'd0, level: 0,    pre: 0,    start: 100,  step: 1,  exp0: 100,  exp_step: 1,  exp_done: 1025};
    vecs[1] = '{mode: 2'd3, level: 0,    pre: 5,    start: 0,    step: 1,  exp0: 0,    exp_step: 1,  exp_done: 1025};
    vecs[2] = '{mode: 2'd1, level: 2048, pre: 100,  start: 1500, step: 1,  exp0: 1948, exp_step: 1,  exp_done: 1473};
    vecs[3] = '{mode: 2'd2, level: 1000, pre: 1023, start: 3000, step: -1, exp0: 2022, exp_step: -1, exp_done: 2003};
    vecs[4] = '{mode: 2'd1, level: 10,   pre: 1,    start: 4000, step: 1,  exp0: 9,    exp_step: 1,  exp_done: 1130};

    // Reset values
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_output("rst_state", state, ST_IDLE);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_wren", bus.ram_wren, 0);
    check_output("rst_rden", bus.ram_rden, 0);
    check_output("rst_rd_data", bus.rd_data, 0);
    rst_n = 1'b1;

    // Table-driven captures
    for (int i = 0; i < 5; i++) begin
      $display("[TB] capture vector %0d", i);
      apply_stimulus(vecs[i].mode, vecs[i].level, vecs[i].pre, vecs[i].start,
                     vecs[i].step, arm_cyc);
      @(negedge sys_clk);
      check_output("busy_after_arm", busy, 1);
      finish_capture(vecs[i], arm_cyc);
    end

    // rd_req while waiting for a trigger that never comes
    $display("[TB] rd_req during WAIT_TRIG");
    apply_stimulus(TRIG_RISE, 4000, 0, 0, 0, arm_cyc);
    repeat (5) @(negedge sys_clk);
    check_output("wait_state", state, ST_WAIT_TRIG);
    rden_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge sys_clk);
      #1;
      bus.rd_req = 1'b1;
      @(negedge sys_clk);
      rden_seen = rden_seen | bus.ram_rden;
    end
    bus.rd_req = 1'b0;
    check_output("rden_in_wait", rden_seen, 0);

    // Re-arm in the middle of POST
    $display("[TB] re-arm during POST");
    apply_stimulus(TRIG_IMM, 0, 0, 100, 1, arm_cyc);
    repeat (50) @(negedge sys_clk);
    check_output("post_state", state, ST_POST);
    apply_stimulus(vecs[2].mode, vecs[2].level, vecs[2].pre, vecs[2].start,
                   vecs[2].step, arm_cyc);
    @(negedge sys_clk);
    check_output("rearm_post_state", state, ST_PRE);
    check_output("rearm_post_done", done, 0);
    finish_capture(vecs[2], arm_cyc);

    // Re-arm in the middle of readout, with arm and rd_req together
    $display("[TB] re-arm during readout");
    apply_stimulus(TRIG_IMM, 0, 0, 100, 1, arm_cyc);
    wait_state(ST_DONE, 2000, seen);
    check_output("readout_done_seen", seen - arm_cyc, 1025);
    read_words(500, 100, 1);
    repeat (3) @(posedge sys_clk);
    #1;
    bus.rd_req = 1'b1;
    @(posedge sys_clk);
    #1;
    trig_mode  = vecs[1].mode;
    trig_level = DATA_W'(vecs[1].level);
    pretrig    = ADDR_W'(vecs[1].pre);
    ramp_start = vecs[1].start;
    ramp_step  = vecs[1].step;
    arm        = 1'b1;
    arm_cyc    = cycle_cnt;
    @(negedge sys_clk);
    check_output("rden_with_arm", bus.ram_rden, 0);
    @(posedge sys_clk);
    #1;
    arm = 1'b0;
    bus.rd_req = 1'b0;
    @(negedge sys_clk);
    check_output("rearm_read_state", state, ST_PRE);
    check_output("rearm_read_done", done, 0);
    finish_capture(vecs[1], arm_cyc);

    // Asynchronous reset during POST
    $display("[TB] reset during POST");
    apply_stimulus(TRIG_IMM, 0, 0, 7, 1, arm_cyc);
    repeat (30) @(negedge sys_clk);
    check_output("post_before_reset", state, ST_POST);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_state", state, ST_IDLE);
    check_output("arst_busy", busy, 0);
    check_output("arst_done", done, 0);
    check_output("arst_wren", bus.ram_wren, 0);
    check_output("arst_rden", bus.ram_rden, 0);
    check_output("arst_rd_valid", bus.rd_valid, 0);
    check_output("arst_rd_data", bus.rd_data, 0);
    check_output("arst_addr", bus.ram_addr, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    apply_stimulus(vecs[4].mode, vecs[4].level, vecs[4].pre, vecs[4].start,
                   vecs[4].step, arm_cyc);
    finish_capture(vecs[4], arm_cyc);

    repeat (4) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
